mode_sequencer: RTL and testbench

- Parametrised successor to the two-mode encoder/decoder selector.
- Cycles among NUM_MODES operating modes (e.g. encoder, decoder, playback) from two raw push-buttons with built-in debounce.
- Defers a switch while the active mode reports busy. On each switch it issues a clear pulse to the incoming mode and blanks the display.
- Muxes the selected mode's 64-bit segment bus to the display driver.

---
 rtl/mode_sequencer.sv | 203 ++++++++++++++++++++
 tb/tb_mode_sequencer.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mode_sequencer.sv
// mode_sequencer: cycles among NUM_MODES operating modes from two debounced push-buttons.
// A switch is deferred while the active mode is busy. Each switch is followed by a flush
// window in which the incoming mode receives a clear strobe and the display is blanked.
//
// Ports:
//   clk          system clock
//   rst          asynchronous active-low reset
//   btn_next     raw button, advance to the next mode
//   btn_prev     raw button, go back to the previous mode
//   busy         per-mode busy; only the bit of the current mode is observed
//   seg_in       packed segment buses, mode i at [i*SEG_W +: SEG_W]
//   seg_out      registered segment bus of the current mode (zero during flush)
//   mode         current mode index
//   mode_onehot  one-hot of mode
//   mode_clr     clear strobe to the incoming mode, held for the whole flush window
//   pending      a switch request is waiting for busy to drop
module mode_sequencer #(
  parameter int unsigned NUM_MODES    = 3,
  parameter int unsigned MODE_W       = 2,
  parameter int unsigned SEG_W        = 64,
  parameter int unsigned DEB_CYCLES   = 16,
  parameter int unsigned FLUSH_CYCLES = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       btn_next,
  input  logic                       btn_prev,
  input  logic [NUM_MODES-1:0]       busy,
  input  logic [NUM_MODES*SEG_W-1:0] seg_in,
  output logic [SEG_W-1:0]           seg_out,
  output logic [MODE_W-1:0]          mode,
  output logic [NUM_MODES-1:0]       mode_onehot,
  output logic [NUM_MODES-1:0]       mode_clr,
  output logic                       pending
);

  localparam int unsigned CntW = $clog2(DEB_CYCLES);
  localparam int unsigned FlW  = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

  typedef enum logic [1:0] {StIdle, StWait, StFlush} state_e;

  // Bit 0 is the next button, bit 1 the prev button.
  logic [1:0] btn_raw;
  logic [1:0] req;

  assign btn_raw = {btn_prev, btn_next};

  for (genvar b = 0; b < 2; b++) begin : g_deb
    logic [1:0]      sync_q;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            level_q, level_d;
    logic            level_prev_q;

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        sync_q       <= '0;
        cnt_q        <= '0;
        level_q      <= 1'b0;
        level_prev_q <= 1'b0;
      end else begin
        sync_q       <= {sync_q[0], btn_raw[b]};
        cnt_q        <= cnt_d;
        level_q      <= level_d;
        level_prev_q <= level_q;
      end
    end

    // cnt_q holds the number of consecutive cycles already seen differing from level_q;
    // the level flips on the DEB_CYCLES-th such cycle. Any agreeing cycle restarts the count.
    always_comb begin
      cnt_d   = '0;
      level_d = level_q;
      if (sync_q[1] != level_q) begin
        if (cnt_q == CntW'(DEB_CYCLES - 1)) begin
          level_d = sync_q[1];
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
    end

    assign req[b] = level_q & ~level_prev_q;
  end

  state_e                 state_q, state_d;
  logic [MODE_W-1:0]      mode_q, mode_d;
  logic [NUM_MODES-1:0]   onehot_q, onehot_d;
  logic                   pending_q, pending_d;
  logic                   dir_q, dir_d;  // 1 = prev
  logic [FlW-1:0]         fl_cnt_q, fl_cnt_d;
  logic [SEG_W-1:0]       seg_q, seg_d;

  logic                   req_one;
  logic                   busy_cur;
  logic                   commit;
  logic                   commit_prev;
  logic [MODE_W-1:0]      next_mode, prev_mode;
  logic [SEG_W-1:0]       seg_sel;

  // Simultaneous requests cancel.
  assign req_one  = req[0] ^ req[1];
  assign busy_cur = |(busy & onehot_q);

  assign next_mode = (mode_q == MODE_W'(NUM_MODES - 1)) ? '0 : mode_q + 1'b1;
  assign prev_mode = (mode_q == '0) ? MODE_W'(NUM_MODES - 1) : mode_q - 1'b1;

  always_comb begin
    seg_sel = '0;
    for (int unsigned i = 0; i < NUM_MODES; i++) begin
      if (mode_q == MODE_W'(i)) begin
        seg_sel = seg_in[i*SEG_W +: SEG_W];
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    mode_d      = mode_q;
    pending_d   = pending_q;
    dir_d       = dir_q;
    fl_cnt_d    = fl_cnt_q;
    commit      = 1'b0;
    commit_prev = dir_q;

    unique case (state_q)
      StIdle: begin
        if (req_one) begin
          if (!busy_cur) begin
            commit      = 1'b1;
            commit_prev = req[1];
          end else begin
            dir_d     = req[1];
            pending_d = 1'b1;
            state_d   = StWait;
          end
        end
      end
      StWait: begin
        if (req_one) begin
          dir_d = req[1];
        end
        // A request arriving in the same cycle busy drops still decides the direction.
        if (!busy_cur) begin
          commit      = 1'b1;
          commit_prev = dir_d;
          pending_d   = 1'b0;
        end
      end
      StFlush: begin
        // Requests are dropped here.
        if (fl_cnt_q == FlW'(FLUSH_CYCLES - 1)) begin
          state_d = StIdle;
        end else begin
          fl_cnt_d = fl_cnt_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase

    if (commit) begin
      state_d  = StFlush;
      fl_cnt_d = '0;
      mode_d   = commit_prev ? prev_mode : next_mode;
    end
  end

  always_comb begin
    onehot_d = '0;
    for (int unsigned i = 0; i < NUM_MODES; i++) begin
      onehot_d[i] = (mode_d == MODE_W'(i));
    end
  end

  // Blank from the commit edge onward so the outgoing mode's data never shows in flush.
  assign seg_d = (state_d == StFlush) ? '0 : seg_sel;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= StIdle;
      mode_q    <= '0;
      onehot_q  <= NUM_MODES'(1);
      pending_q <= 1'b0;
      dir_q     <= 1'b0;
      fl_cnt_q  <= '0;
      seg_q     <= '0;
    end else begin
      state_q   <= state_d;
      mode_q    <= mode_d;
      onehot_q  <= onehot_d;
      pending_q <= pending_d;
      dir_q     <= dir_d;
      fl_cnt_q  <= fl_cnt_d;
      seg_q     <= seg_d;
    end
  end

  assign mode        = mode_q;
  assign mode_onehot = onehot_q;
  assign mode_clr    = (state_q == StFlush) ? onehot_q : '0;
  assign pending     = pending_q;
  assign seg_out     = seg_q;

endmodule

// File: tb/tb_mode_sequencer.sv
module tb_mode_sequencer;

  localparam int DEB = 16;
  localparam logic [63:0] S0 = 64'h0123_4567_89ab_cdef;
  localparam logic [63:0] S1 = 64'hf0e1_d2c3_b4a5_9687;
  localparam logic [63:0] S2 = 64'h5a5a_a5a5_3c3c_c3c3;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         btn_next = 1'b0;
  logic         btn_prev = 1'b0;
  logic [2:0]   busy = 3'b000;
  logic         seg_on = 1'b0;
  logic [191:0] seg_in;
  logic [63:0]  seg_out;
  logic [1:0]   mode;
  logic [2:0]   mode_onehot;
  logic [2:0]   mode_clr;
  logic         pending;

  assign seg_in = seg_on ? {S2, S1, S0} : '0;

  mode_sequencer #(
    .NUM_MODES   (3),
    .MODE_W      (2),
    .SEG_W       (64),
    .DEB_CYCLES  (DEB),
    .FLUSH_CYCLES(4)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .btn_next   (btn_next),
    .btn_prev   (btn_prev),
    .busy       (busy),
    .seg_in     (seg_in),
    .seg_out    (seg_out),
    .mode       (mode),
    .mode_onehot(mode_onehot),
    .mode_clr   (mode_clr),
    .pending    (pending)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Flush observer, sampled on the falling edge.
  int          clr_total = 0;
  int          ends = 0;
  int          seg_bad = 0;
  logic [2:0]  clr_last = '0;
  logic [2:0]  prev_clr = '0;
  logic [63:0] seg_after = '0;

  always @(negedge clk) begin
    if (mode_clr != 3'b000) begin
      clr_total = clr_total + 1;
      clr_last  = mode_clr;
      if (seg_out != 64'd0) seg_bad = seg_bad + 1;
    end else if (prev_clr != 3'b000) begin
      ends      = ends + 1;
      seg_after = seg_out;
    end
    prev_clr = mode_clr;
  end

  typedef struct packed {
    logic [1:0] mode;
    logic [2:0] clr;
    logic [7:0] n;
  } exp_t;

  exp_t       sb[$];
  logic [1:0] model_mode = 2'd0;
  int         c0, e0, b0;

  function automatic logic [63:0] slice(input logic [1:0] m);
    if (!seg_on) return 64'd0;
    case (m)
      2'd0:    return S0;
      2'd1:    return S1;
      default: return S2;
    endcase
  endfunction

  function automatic logic [1:0] nxt(input logic [1:0] m);
    return (m == 2'd2) ? 2'd0 : m + 2'd1;
  endfunction

  function automatic logic [1:0] prv(input logic [1:0] m);
    return (m == 2'd0) ? 2'd2 : m - 2'd1;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] want);
    n_cmp++;
    assert (obs === want) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, want);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic nx, input logic pv, input int n);
    btn_next = nx;
    btn_prev = pv;
    cyc(n);
  endtask

  task automatic press(input logic nx, input logic pv);
    drive(nx, pv, DEB + 4);
    drive(1'b0, 1'b0, DEB + 8);
  endtask

  task automatic snap();
    c0 = clr_total;
    e0 = ends;
    b0 = seg_bad;
  endtask

  task automatic expect_switch(input logic [1:0] m, input int n);
    exp_t e;
    model_mode = m;
    e.mode = m;
    e.clr  = (n != 0) ? (3'b001 << m) : 3'b000;
    e.n    = 8'(n);
    sb.push_back(e);
  endtask

  task automatic check_step(input string tag);
    exp_t e;
    chk({tag, ".sb"}, 64'(sb.size() != 0), 64'd1);
    e = sb.pop_front();
    chk({tag, ".mode"}, 64'(mode), 64'(e.mode));
    chk({tag, ".onehot"}, 64'(mode_onehot), 64'(3'b001 << e.mode));
    chk({tag, ".clr_cycles"}, 64'(clr_total - c0), 64'(e.n));
    chk({tag, ".flush_ends"}, 64'(ends - e0), (e.n != 0) ? 64'd1 : 64'd0);
    if (e.n != 0) begin
      chk({tag, ".clr_val"}, 64'(clr_last), 64'(e.clr));
      chk({tag, ".seg_after_flush"}, seg_after, slice(e.mode));
    end
    chk({tag, ".seg_in_flush"}, 64'(seg_bad - b0), 64'd0);
    chk({tag, ".seg_out"}, seg_out, slice(e.mode));
    chk({tag, ".clr_idle"}, 64'(mode_clr), 64'd0);
    chk({tag, ".pending"}, 64'(pending), 64'd0);
  endtask

  initial begin
    logic found;
    int   waited;

    // Reset values.
    cyc(3);
    chk("rst.mode", 64'(mode), 64'd0);
    chk("rst.onehot", 64'(mode_onehot), 64'd1);
    chk("rst.clr", 64'(mode_clr), 64'd0);
    chk("rst.pending", 64'(pending), 64'd0);
    chk("rst.seg_out", seg_out, 64'd0);
    rst = 1'b1;
    cyc(2);

    // Glitch shorter than the debounce window.
    snap();
    expect_switch(2'd0, 0);
    drive(1'b1, 1'b0, DEB - 2);
    drive(1'b0, 1'b0, DEB + 8);
    check_step("glitch");

    seg_on = 1'b1;
    cyc(2);

    // Basic next, then back.
    snap();
    expect_switch(nxt(model_mode), 4);
    press(1'b1, 1'b0);
    check_step("next_0to1");

    snap();
    expect_switch(prv(model_mode), 4);
    press(1'b0, 1'b1);
    check_step("prev_1to0");

    // Busy deferral with direction overwrite.
    busy = 3'b001;
    snap();
    press(1'b1, 1'b0);
    chk("busy.pending", 64'(pending), 64'd1);
    chk("busy.mode_held", 64'(mode), 64'd0);
    press(1'b0, 1'b1);
    chk("busy.pending2", 64'(pending), 64'd1);
    chk("busy.mode_held2", 64'(mode), 64'd0);
    chk("busy.no_clr", 64'(clr_total - c0), 64'd0);
    expect_switch(prv(model_mode), 4);
    busy = 3'b000;
    cyc(12);
    check_step("busy_release");

    // Wrap-around both ways.
    snap();
    expect_switch(nxt(model_mode), 4);
    press(1'b1, 1'b0);
    check_step("wrap_next");

    snap();
    expect_switch(prv(model_mode), 4);
    press(1'b0, 1'b1);
    check_step("wrap_prev");

    // Simultaneous requests cancel.
    snap();
    expect_switch(model_mode, 0);
    press(1'b1, 1'b1);
    check_step("simul");

    // Second request lands inside the flush window and is dropped.
    snap();
    expect_switch(nxt(model_mode), 4);
    btn_next = 1'b1;
    cyc(2);
    btn_prev = 1'b1;
    cyc(DEB + 4);
    drive(1'b0, 1'b0, DEB + 8);
    check_step("flush_drop");

    // Reset in the second flush cycle.
    found  = 1'b0;
    waited = 0;
    btn_next = 1'b1;
    while (!found && waited < 3 * DEB) begin
      @(negedge clk);
      waited++;
      if (mode_clr != 3'b000) found = 1'b1;
    end
    chk("rstflush.flush_seen", 64'(found), 64'd1);
    @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    chk("rstflush.mode", 64'(mode), 64'd0);
    chk("rstflush.onehot", 64'(mode_onehot), 64'd1);
    chk("rstflush.clr", 64'(mode_clr), 64'd0);
    chk("rstflush.seg_out", seg_out, 64'd0);
    chk("rstflush.pending", 64'(pending), 64'd0);
    btn_next = 1'b0;
    cyc(3);
    rst = 1'b1;
    model_mode = 2'd0;
    cyc(DEB + 8);

    snap();
    expect_switch(nxt(model_mode), 4);
    press(1'b1, 1'b0);
    check_step("after_rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
